// File: rtl/nn_sched.sv
// -----------------------------------------------------------------------------
// nn_sched
//   Sequencer for a 784-30-15-10 dense classifier that time-multiplexes one
//   shared FP32 multiply-accumulate datapath. Walks every neuron of the three
//   layers and emits weight-ROM reads, activation reads, accumulate enables,
//   bias substitution and activation-buffer writes. The datapath only obeys
//   these strobes; no data passes through this block.
//
// Parameters
//   RD_LAT  read latency of weight ROM / activation buffers (>= 1)
//   AW      weight-ROM address width
//
// Ports
//   Clk, Reset_n   clock (rising edge), asynchronous active-low reset
//   start          begin one inference (only sampled in IDLE)
//   stall          hold issue while in MAC (memory not ready)
//   busy, done     run in progress / one-cycle completion pulse
//   layer          current layer 0..2
//   w_rd, w_addr   weight/bias read strobe and address
//   act_rd_addr    activation index i
//   act_src        0 image bit, 1 buffer A, 2 buffer B (issue-aligned)
//   act_one        substitute 1.0 for the activation (bias term)
//   acc_en         accumulate product (w_rd delayed by RD_LAT)
//   acc_clr        clear accumulator at this edge
//   act_wr, act_wr_addr, act_wr_sel, relu_en
//                  write accumulator result to neuron j of A(1)/B(2)/logits(3)
// -----------------------------------------------------------------------------
module nn_sched #(
  parameter int RD_LAT = 1,
  parameter int AW     = 15
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic [1:0]    layer,
  output logic          w_rd,
  output logic [AW-1:0] w_addr,
  output logic [9:0]    act_rd_addr,
  output logic [1:0]    act_src,
  output logic          act_one,
  output logic          acc_en,
  output logic          acc_clr,
  output logic          act_wr,
  output logic [4:0]    act_wr_addr,
  output logic [1:0]    act_wr_sel,
  output logic          relu_en
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_e;

  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e            state_q, state_d;
  logic [9:0]        i_q, i_d;
  logic [4:0]        j_q, j_d;
  logic [1:0]        layer_q, layer_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [RD_LAT-1:0] acc_sr_q, acc_sr_d;

  // Per-layer geometry
  logic [9:0]    n_in;
  logic [4:0]    n_out;
  logic [AW-1:0] w_base, b_base;
  logic [1:0]    src, dst;

  logic bias_term;
  logic last_neuron;
  logic issue;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    n_in   = 10'd784;
    n_out  = 5'd30;
    w_base = '0;
    b_base = AW'(23520);
    src    = 2'd0;
    dst    = 2'd1;
    case (layer_q)
      2'd1: begin
        n_in   = 10'd30;
        n_out  = 5'd15;
        w_base = AW'(23550);
        b_base = AW'(24000);
        src    = 2'd1;
        dst    = 2'd2;
      end
      2'd2: begin
        n_in   = 10'd15;
        n_out  = 5'd10;
        w_base = AW'(24015);
        b_base = AW'(24165);
        src    = 2'd2;
        dst    = 2'd3;
      end
      default: ;
    endcase
  end

  // The issue slot after the last activation is the bias term.
  assign bias_term   = (i_q == n_in);
  assign last_neuron = (j_q == n_out - 5'd1);
  assign issue       = (state_q == S_MAC) && !stall;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    layer_d = layer_q;
    drain_d = drain_q;

    // acc_en is w_rd delayed by RD_LAT, matching the memory read latency.
    acc_sr_d    = '0;
    acc_sr_d[0] = issue;
    for (int k = 1; k < RD_LAT; k++) acc_sr_d[k] = acc_sr_q[k-1];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
          i_d     = '0;
          j_d     = '0;
          layer_d = '0;
          drain_d = '0;
        end
      end
      S_MAC: begin
        if (!stall) begin
          if (bias_term) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            i_d = i_q + 10'd1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(RD_LAT - 1)) state_d = S_WRITE;
        else                            drain_d = drain_q + 1'b1;
      end
      S_WRITE: begin
        i_d = '0;
        if (!last_neuron) begin
          j_d     = j_q + 5'd1;
          state_d = S_MAC;
        end else if (layer_q != 2'd2) begin
          layer_d = layer_q + 2'd1;
          j_d     = '0;
          state_d = S_MAC;
        end else begin
          // Park counters at zero so layer reads 0 while idle.
          layer_d = '0;
          j_d     = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the delay line
  // resets with everything else so no stale acc_en survives a mid-run reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      layer_q  <= '0;
      drain_q  <= '0;
      acc_sr_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      layer_q  <= layer_d;
      drain_q  <= drain_d;
      acc_sr_q <= acc_sr_d;
    end
  end

  // Address generation; operands are widened to AW before the multiply so
  // i*N_out (up to 23520) is not truncated to the 10-bit index width.
  always_comb begin
    w_addr      = '0;
    act_rd_addr = '0;
    act_src     = '0;
    if (state_q == S_MAC) begin
      act_src = src;
      if (bias_term) begin
        w_addr = b_base + AW'(j_q);
      end else begin
        w_addr      = w_base + AW'(i_q) * AW'(n_out) + AW'(j_q);
        act_rd_addr = i_q;
      end
    end
  end

  assign busy        = (state_q == S_MAC) || (state_q == S_DRAIN) || (state_q == S_WRITE);
  assign done        = (state_q == S_DONE);
  assign layer       = layer_q;
  assign w_rd        = issue;
  assign act_one     = issue && bias_term;
  assign acc_en      = acc_sr_q[RD_LAT-1];
  assign act_wr      = (state_q == S_WRITE);
  assign acc_clr     = (state_q == S_WRITE);
  assign act_wr_addr = (state_q == S_WRITE) ? j_q : 5'd0;
  assign act_wr_sel  = (state_q == S_WRITE) ? dst : 2'd0;
  assign relu_en     = (state_q == S_WRITE) && (layer_q != 2'd2);

endmodule

// File: tb/tb_nn_sched.sv
// -----------------------------------------------------------------------------
// tb_nn_sched
//   Two sequencer instances (RD_LAT=1 and RD_LAT=3) drive an integer stand-in
//   for the MAC datapath kept in the bench. Expected issue order, write order,
//   run length and logits are derived from the layer table with plain loops.
// -----------------------------------------------------------------------------
module tb_nn_sched;

  localparam int AW        = 15;
  localparam int ROM_WORDS = 24175;
  localparam int LATS   [2] = '{1, 3};
  localparam int N_IN   [3] = '{784, 30, 15};
  localparam int N_OUT  [3] = '{30, 15, 10};
  localparam int W_BASE [3] = '{0, 23550, 24015};
  localparam int B_BASE [3] = '{23520, 24000, 24165};
  localparam int SRC    [3] = '{0, 1, 2};
  localparam int DST    [3] = '{1, 2, 3};

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       stall;
  logic [1:0] start_v;

  logic [1:0]    busy_v, done_v, w_rd_v, act_one_v, acc_en_v, acc_clr_v, act_wr_v, relu_en_v;
  logic [1:0]    layer_a       [2];
  logic [AW-1:0] w_addr_a      [2];
  logic [9:0]    act_rd_addr_a [2];
  logic [1:0]    act_src_a     [2];
  logic [4:0]    act_wr_addr_a [2];
  logic [1:0]    act_wr_sel_a  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    nn_sched #(.RD_LAT(LATS[g]), .AW(AW)) u_dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .start       (start_v[g]),
      .stall       (stall),
      .busy        (busy_v[g]),
      .done        (done_v[g]),
      .layer       (layer_a[g]),
      .w_rd        (w_rd_v[g]),
      .w_addr      (w_addr_a[g]),
      .act_rd_addr (act_rd_addr_a[g]),
      .act_src     (act_src_a[g]),
      .act_one     (act_one_v[g]),
      .acc_en      (acc_en_v[g]),
      .acc_clr     (acc_clr_v[g]),
      .act_wr      (act_wr_v[g]),
      .act_wr_addr (act_wr_addr_a[g]),
      .act_wr_sel  (act_wr_sel_a[g]),
      .relu_en     (relu_en_v[g])
    );
  end

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Stimulus data and golden forward pass
  int rom [ROM_WORDS];
  int img [784];
  int gold_h1 [30];
  int gold_h2 [15];
  int gold_lg [10];

  // Per-instance model state
  int m_l [2], m_j [2], m_i [2];
  int wl [2], wj [2];
  int acc [2];
  int prod [2][8];
  bit vld  [2][8];
  int ba [2][30];
  int bb [2][15];
  int lg [2][10];
  int n_rd [2], n_acc [2], n_relu [2], n_done [2], done_cyc [2], last_addr [2];
  int n_wr [2][4];

  function automatic int exp_addr(input int l, input int j, input int i);
    if (i < N_IN[l]) return W_BASE[l] + i * N_OUT[l] + j;
    return B_BASE[l] + j;
  endfunction

  function automatic longint pack_outs(input int d);
    return longint'({busy_v[d], done_v[d], layer_a[d], w_rd_v[d], w_addr_a[d],
                     act_rd_addr_a[d], act_src_a[d], act_one_v[d], acc_en_v[d],
                     acc_clr_v[d], act_wr_v[d], act_wr_addr_a[d], act_wr_sel_a[d],
                     relu_en_v[d]});
  endfunction

  function automatic int total_issues();
    int s = 0;
    for (int l = 0; l < 3; l++) s += N_OUT[l] * (N_IN[l] + 1);
    return s;
  endfunction

  function automatic int total_cycles(input int lat);
    int s = 0;
    for (int l = 0; l < 3; l++) s += N_OUT[l] * (N_IN[l] + 1 + lat + 1);
    return s;
  endfunction

  task automatic model_init(input int d);
    m_l[d] = 0; m_j[d] = 0; m_i[d] = 0;
    wl[d] = 0;  wj[d] = 0;  acc[d] = 0;
    n_rd[d] = 0; n_acc[d] = 0; n_relu[d] = 0; n_done[d] = 0;
    done_cyc[d] = -1; last_addr[d] = -1;
    for (int k = 0; k < 8; k++) begin prod[d][k] = 0; vld[d][k] = 1'b0; end
    for (int k = 0; k < 4; k++) n_wr[d][k] = 0;
    for (int k = 0; k < 30; k++) ba[d][k] = 0;
    for (int k = 0; k < 15; k++) bb[d][k] = 0;
    for (int k = 0; k < 10; k++) lg[d][k] = 0;
  endtask

  // Integer datapath stand-in plus issue/write order checks, one instance.
  task automatic observe(input int d);
    int  slot, pslot, v, opnd, ea, val, a, exp_ctl, got_ctl;
    bit  bias;
    slot  = cyc & 7;
    pslot = (cyc - LATS[d]) & 7;
    v     = 0;

    if (stall) check("no_w_rd_while_stalled", longint'(w_rd_v[d]), 0);

    if (acc_en_v[d]) begin
      n_acc[d]++;
      check("acc_en_lag", longint'(vld[d][pslot]), 1);
      v = prod[d][pslot];
    end

    vld[d][slot]  = w_rd_v[d];
    prod[d][slot] = 0;
    if (w_rd_v[d]) begin
      n_rd[d]++;
      last_addr[d] = int'(w_addr_a[d]);
      a = int'(act_rd_addr_a[d]);
      if (act_one_v[d]) opnd = 1;
      else begin
        case (act_src_a[d])
          2'd0:    opnd = (a < 784) ? img[a] : 0;
          2'd1:    opnd = (a < 30)  ? ba[d][a] : 0;
          2'd2:    opnd = (a < 15)  ? bb[d][a] : 0;
          default: opnd = 0;
        endcase
      end
      prod[d][slot] = (last_addr[d] < ROM_WORDS) ? rom[last_addr[d]] * opnd : 0;

      if (m_l[d] > 2) check("extra_w_rd", 1, 0);
      else begin
        ea   = exp_addr(m_l[d], m_j[d], m_i[d]);
        bias = (m_i[d] == N_IN[m_l[d]]);
        check("w_addr", longint'(w_addr_a[d]), longint'(ea));
        exp_ctl = (m_l[d] << 13) | (int'(bias) << 12) | (SRC[m_l[d]] << 10) | (bias ? 0 : m_i[d]);
        got_ctl = (int'(layer_a[d]) << 13) | (int'(act_one_v[d]) << 12) |
                  (int'(act_src_a[d]) << 10) | (bias ? 0 : a);
        check("issue_ctl", longint'(got_ctl), longint'(exp_ctl));
        m_i[d]++;
        if (m_i[d] > N_IN[m_l[d]]) begin
          m_i[d] = 0;
          m_j[d]++;
          if (m_j[d] == N_OUT[m_l[d]]) begin m_j[d] = 0; m_l[d]++; end
        end
      end
    end

    if (act_wr_v[d]) begin
      val = acc[d];
      if (wl[d] > 2) check("extra_act_wr", 1, 0);
      else begin
        exp_ctl = (wj[d] << 3) | (DST[wl[d]] << 1) | ((wl[d] < 2) ? 1 : 0);
        got_ctl = (int'(act_wr_addr_a[d]) << 3) | (int'(act_wr_sel_a[d]) << 1) | int'(relu_en_v[d]);
        check("act_wr_ctl", longint'(got_ctl), longint'(exp_ctl));
        wj[d]++;
        if (wj[d] == N_OUT[wl[d]]) begin wj[d] = 0; wl[d]++; end
      end
      if (relu_en_v[d]) begin n_relu[d]++; if (val < 0) val = 0; end
      a = int'(act_wr_addr_a[d]);
      n_wr[d][act_wr_sel_a[d]]++;
      case (act_wr_sel_a[d])
        2'd1:    if (a < 30) ba[d][a] = val;
        2'd2:    if (a < 15) bb[d][a] = val;
        2'd3:    if (a < 10) lg[d][a] = val;
        default: ;
      endcase
    end

    acc[d] = acc_clr_v[d] ? 0 : acc[d] + v;

    if (done_v[d]) begin
      n_done[d]++;
      done_cyc[d] = cyc;
      check("busy_low_at_done", longint'(busy_v[d]), 0);
    end
  endtask

  always @(negedge Clk) begin
    for (int d = 0; d < 2; d++) observe(d);
  end

  // One inference on the selected instances, optionally with 100 MAC stalls
  // placed on instance 0 (RD_LAT=1).
  task automatic run(input logic [1:0] use_v, input bit with_stall);
    int s0, off, ptr, per_n;
    bit fin;
    int keys[$];
    int stall_off[$];
    for (int d = 0; d < 2; d++) if (use_v[d]) model_init(d);
    if (with_stall) begin
      // Key (neuron k of layer 0, issue index i); the m-th stall in sorted
      // order lands m cycles late because of the stalls before it.
      per_n = N_IN[0] + 2 + LATS[0];
      repeat (100) keys.push_back(int'($urandom_range(29, 0)) * 1000 + int'($urandom_range(784, 0)));
      keys.sort();
      foreach (keys[m]) stall_off.push_back(1 + (keys[m] / 1000) * per_n + keys[m] % 1000 + m);
    end
    @(posedge Clk); #1;
    start_v = use_v;
    s0  = cyc;
    ptr = 0;
    fin = 1'b0;
    while (!fin) begin
      @(posedge Clk); #1;
      off     = cyc - s0;
      start_v = 2'b00;
      if (off == 1)
        for (int d = 0; d < 2; d++) if (use_v[d]) check("busy_after_start", longint'(busy_v[d]), 1);
      stall = with_stall && (ptr < stall_off.size()) && (stall_off[ptr] == off);
      if (stall) ptr++;
      fin = 1'b1;
      for (int d = 0; d < 2; d++) if (use_v[d] && n_done[d] == 0) fin = 1'b0;
      if (off > 30000) begin check("run_timeout", 0, 1); fin = 1'b1; end
    end
    stall = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (use_v[d]) begin
        check("done_cycle", longint'(done_cyc[d] - s0),
              longint'(1 + total_cycles(LATS[d]) + ((with_stall && d == 0) ? 100 : 0)));
        check("done_pulses", longint'(n_done[d]), 1);
        check("w_rd_count", longint'(n_rd[d]), longint'(total_issues()));
        check("acc_en_count", longint'(n_acc[d]), longint'(total_issues()));
        check("writes_a", longint'(n_wr[d][1]), longint'(N_OUT[0]));
        check("writes_b", longint'(n_wr[d][2]), longint'(N_OUT[1]));
        check("writes_logit", longint'(n_wr[d][3]), longint'(N_OUT[2]));
        check("relu_writes", longint'(n_relu[d]), longint'(N_OUT[0] + N_OUT[1]));
        check("last_bias_addr", longint'(last_addr[d]), 24174);
        check("idle_after_run", pack_outs(d), 0);
        for (int k = 0; k < 10; k++) check("logit", longint'(lg[d][k]), longint'(gold_lg[k]));
      end
    end
  endtask

  task automatic run_reset_mid();
    int guard;
    model_init(0);
    @(posedge Clk); #1;
    start_v = 2'b01;
    @(posedge Clk); #1;
    start_v = 2'b00;
    guard = 0;
    while (!(wl[0] == 1 && wj[0] == 7) && guard < 30000) begin
      @(posedge Clk);
      guard++;
    end
    check("reached_layer1_j7", longint'((wl[0] == 1 && wj[0] == 7) ? 1 : 0), 1);
    repeat (5) @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1 check("async_reset_outs", pack_outs(0), 0);
    model_init(0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (20) @(posedge Clk);
    #1;
    check("no_done_after_reset", longint'(n_done[0]), 0);
    check("idle_after_reset", pack_outs(0), 0);
  endtask

  initial begin
    int s;
    Reset_n = 1'b0;
    stall   = 1'b0;
    start_v = 2'b00;

    for (int k = 0; k < ROM_WORDS; k++) rom[k] = int'($urandom_range(6, 0)) - 3;
    for (int k = 0; k < 784; k++) img[k] = int'($urandom_range(1, 0));
    for (int j = 0; j < 30; j++) begin
      s = rom[B_BASE[0] + j];
      for (int i = 0; i < 784; i++) s += rom[W_BASE[0] + i * 30 + j] * img[i];
      gold_h1[j] = (s < 0) ? 0 : s;
    end
    for (int j = 0; j < 15; j++) begin
      s = rom[B_BASE[1] + j];
      for (int i = 0; i < 30; i++) s += rom[W_BASE[1] + i * 15 + j] * gold_h1[i];
      gold_h2[j] = (s < 0) ? 0 : s;
    end
    for (int j = 0; j < 10; j++) begin
      s = rom[B_BASE[2] + j];
      for (int i = 0; i < 15; i++) s += rom[W_BASE[2] + i * 10 + j] * gold_h2[i];
      gold_lg[j] = s;
    end
    for (int d = 0; d < 2; d++) model_init(d);

    repeat (3) @(posedge Clk);
    #1;
    for (int d = 0; d < 2; d++) check("outs_in_reset", pack_outs(d), 0);
    Reset_n = 1'b1;
    repeat (10) begin
      @(negedge Clk);
      for (int d = 0; d < 2; d++) check("idle_outs", pack_outs(d), 0);
    end

    run_reset_mid();
    run(2'b11, 1'b0);
    run(2'b01, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
